// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store front end for ram256x8.
// Registers one request, checks alignment, runs the mv/moc handshake with a
// two-flop synchronized moc and a bounded wait, and returns extended load data.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_address,
    output logic [1:0]        ram_type,
    output logic              ram_enable,
    output logic              ram_mv,
    input  logic              ram_moc,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [1:0]        err_pend_q, err_pend_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
    logic              ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [1:0]        ram_type_q, ram_type_d;
    logic              ram_enable_q, ram_enable_d;
    logic              ram_mv_q, ram_mv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              moc_s1_q, moc_s1_d;
    logic              moc_s2_q, moc_s2_d;
    logic              is_store_q, is_store_d;
    logic [1:0]        size_q, size_d;
    logic              sign_ext_q, sign_ext_d;

    // Keep only the bytes selected by size; upper bits forced to zero.
    function automatic logic [DATA_W-1:0] mask_store(input logic [1:0] sz,
                                                     input logic [DATA_W-1:0] w);
        case (sz)
            2'b00:   return DATA_W'(w[7:0]);
            2'b01:   return DATA_W'(w[15:0]);
            2'b10:   return DATA_W'(w[31:0]);
            default: return w;
        endcase
    endfunction

    // Sign- or zero-extend the low bytes of a RAM read according to size.
    function automatic logic [DATA_W-1:0] extend_load(input logic [1:0] sz,
                                                      input logic se,
                                                      input logic [DATA_W-1:0] d);
        case (sz)
            2'b00:   return se ? {{(DATA_W-8){d[7]}}, d[7:0]}    : DATA_W'(d[7:0]);
            2'b01:   return se ? {{(DATA_W-16){d[15]}}, d[15:0]} : DATA_W'(d[15:0]);
            2'b10:   return se ? {{(DATA_W-32){d[31]}}, d[31:0]} : DATA_W'(d[31:0]);
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
        case (sz)
            2'b01:   return a[0];
            2'b10:   return |a[1:0];
            2'b11:   return |a[2:0];
            default: return 1'b0;
        endcase
    endfunction

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = ERR_OK;
        err_pend_d    = err_pend_q;
        rdata_d       = rdata_q;
        load_d        = load_q;
        ram_data_in_d = ram_data_in_q;
        ram_rw_d      = ram_rw_q;
        ram_address_d = ram_address_q;
        ram_type_d    = ram_type_q;
        ram_enable_d  = ram_enable_q;
        ram_mv_d      = ram_mv_q;
        cnt_d         = cnt_q;
        moc_s1_d      = ram_moc;
        moc_s2_d      = moc_s1_q;
        is_store_d    = is_store_q;
        size_d        = size_q;
        sign_ext_d    = sign_ext_q;

        case (state_q)
            S_IDLE: begin
                if (req && !busy_q) begin
                    busy_d     = 1'b1;
                    is_store_d = is_store;
                    size_d     = size;
                    sign_ext_d = sign_ext;
                    // Alignment is decided on the values being registered so the
                    // RAM ports are already valid for the whole SETUP cycle.
                    if (misaligned(size, addr)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = ERR_ALIGN;
                    end else begin
                        state_d       = S_SETUP;
                        ram_address_d = addr;
                        ram_rw_d      = ~is_store;
                        ram_type_d    = size;
                        ram_data_in_d = mask_store(size, wdata);
                        ram_enable_d  = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_d  = S_WAIT;
                ram_mv_d = 1'b1;
                cnt_d    = '0;
            end
            S_WAIT: begin
                if (moc_s2_q) begin
                    ram_mv_d   = 1'b0;
                    err_pend_d = ERR_OK;
                    if (!is_store_q) begin
                        load_d = extend_load(size_q, sign_ext_q, ram_data_out);
                    end
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ram_mv_d   = 1'b0;
                    err_pend_d = ERR_TIMEOUT;
                    state_d    = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (!moc_s2_q) begin
                    state_d      = S_DONE;
                    ram_enable_d = 1'b0;
                    done_d       = 1'b1;
                    err_d        = err_pend_q;
                    if (err_pend_q == ERR_OK && !is_store_q) begin
                        rdata_d = load_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, registered outputs and moc synchronizer; reset abandons any access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= ERR_OK;
            err_pend_q    <= ERR_OK;
            rdata_q       <= '0;
            load_q        <= '0;
            ram_data_in_q <= '0;
            ram_rw_q      <= 1'b1;
            ram_address_q <= '0;
            ram_type_q    <= 2'b00;
            ram_enable_q  <= 1'b0;
            ram_mv_q      <= 1'b0;
            cnt_q         <= '0;
            moc_s1_q      <= 1'b0;
            moc_s2_q      <= 1'b0;
            is_store_q    <= 1'b0;
            size_q        <= 2'b00;
            sign_ext_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            err_pend_q    <= err_pend_d;
            rdata_q       <= rdata_d;
            load_q        <= load_d;
            ram_data_in_q <= ram_data_in_d;
            ram_rw_q      <= ram_rw_d;
            ram_address_q <= ram_address_d;
            ram_type_q    <= ram_type_d;
            ram_enable_q  <= ram_enable_d;
            ram_mv_q      <= ram_mv_d;
            cnt_q         <= cnt_d;
            moc_s1_q      <= moc_s1_d;
            moc_s2_q      <= moc_s2_d;
            is_store_q    <= is_store_d;
            size_q        <= size_d;
            sign_ext_q    <= sign_ext_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign ram_data_in = ram_data_in_q;
    assign ram_rw      = ram_rw_q;
    assign ram_address = ram_address_q;
    assign ram_type    = ram_type_q;
    assign ram_enable  = ram_enable_q;
    assign ram_mv      = ram_mv_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small byte-addressed RAM model
// that answers mv with moc after a fixed delay (or never, when ram_dead=1).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [7:0]  addr = '0;
    logic [63:0] wdata = '0;
    logic        busy, done;
    logic [1:0]  err;
    logic [63:0] rdata, ram_data_in;
    logic        ram_rw, ram_enable, ram_mv;
    logic [7:0]  ram_address;
    logic [1:0]  ram_type;
    logic        ram_moc = 1'b0;
    logic [63:0] ram_data_out = '0;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(64), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .req(req), .is_store(is_store), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .ram_data_in(ram_data_in), .ram_rw(ram_rw),
        .ram_address(ram_address), .ram_type(ram_type), .ram_enable(ram_enable),
        .ram_mv(ram_mv), .ram_moc(ram_moc), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // RAM model: little-endian bytes, moc two cycles after mv is seen, upper
    // read bytes filled with A5 so the controller must do the extension itself.
    logic [7:0] mem [256];
    int         dly = 0;
    bit         ram_dead = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            ram_moc <= 1'b0;
            dly     <= 0;
        end else if (ram_mv && ram_enable && !ram_moc) begin
            if (!ram_dead) begin
                if (dly == 2) begin
                    logic [63:0] tmp;
                    tmp = 64'hA5A5_A5A5_A5A5_A5A5;
                    for (int i = 0; i < 8; i++) begin
                        if (i < (1 << ram_type)) begin
                            if (ram_rw == 1'b0) mem[int'(ram_address) + i] <= ram_data_in[8*i +: 8];
                            tmp[8*i +: 8] = mem[int'(ram_address) + i];
                        end
                    end
                    ram_data_out <= tmp;
                    ram_moc      <= 1'b1;
                    dly          <= 0;
                end else begin
                    dly <= dly + 1;
                end
            end
        end else if (!ram_mv) begin
            ram_moc <= 1'b0;
            dly     <= 0;
        end
    end

    // Bus monitor sampled on the falling edge.
    int          mv_cycles = 0, mv_run = 0, last_mv_run = 0, setup_viol = 0, done_count = 0;
    logic        mv_prev = 1'b0, rw_prev = 1'b1, en_prev = 1'b0;
    logic [7:0]  addr_prev = '0;
    logic        rw_at_mv = 1'b1;
    logic [1:0]  type_at_mv = '0;
    logic [63:0] din_at_mv = '0;

    always @(negedge clk) begin
        mv_cycles <= mv_cycles + (ram_mv ? 1 : 0);
        done_count <= done_count + (done ? 1 : 0);
        if (ram_mv && !mv_prev) begin
            if (ram_address !== addr_prev || ram_rw !== rw_prev || en_prev !== 1'b1)
                setup_viol <= setup_viol + 1;
            rw_at_mv   <= ram_rw;
            type_at_mv <= ram_type;
            din_at_mv  <= ram_data_in;
            mv_run     <= 1;
        end else if (ram_mv) begin
            mv_run <= mv_run + 1;
        end
        if (!ram_mv && mv_prev) last_mv_run <= mv_run;
        mv_prev   <= ram_mv;
        rw_prev   <= ram_rw;
        en_prev   <= ram_enable;
        addr_prev <= ram_address;
    end

    // Issue one request; cyc = falling edges after the sampling edge until done.
    task automatic access(input logic st, input logic [1:0] sz, input logic sx,
                          input logic [7:0] a, input logic [63:0] wd,
                          output logic [1:0] e, output logic [63:0] rd,
                          output int cyc, output logic busy_seen);
        @(negedge clk);
        req = 1'b1; is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        cyc = 0;
        busy_seen = busy;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        e  = err;
        rd = rdata;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL access_done_timeout: done=%b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b required 00", err); end
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", rdata); end
        checks++; if (ram_mv !== 1'b0 || ram_enable !== 1'b0) begin errors++; $display("FAIL reset_mv_en: got %b%b required 00", ram_mv, ram_enable); end
        checks++; if (ram_rw !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b required 1", ram_rw); end
        checks++; if (ram_address !== 8'h0 || ram_type !== 2'b00 || ram_data_in !== 64'h0) begin
            errors++; $display("FAIL reset_ram_ports: addr=%h type=%b din=%h required 0", ram_address, ram_type, ram_data_in);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_byte();
        logic [1:0] e; logic [63:0] rd; int cyc; logic b;
        access(1'b1, 2'b00, 1'b0, 8'h02, 64'h1234_5678_9abc_de9a, e, rd, cyc, b);
        checks++; if (e !== 2'b00) begin errors++; $display("FAIL sb_err: got %b required 00", e); end
        checks++; if (rw_at_mv !== 1'b0 || type_at_mv !== 2'b00) begin errors++; $display("FAIL sb_rw_type: rw=%b type=%b required 0/00", rw_at_mv, type_at_mv); end
        checks++; if (din_at_mv !== 64'h9a) begin errors++; $display("FAIL sb_din_mask: got %h required 9a", din_at_mv); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL sb_rdata_hold: got %h required 0", rd); end
        access(1'b0, 2'b00, 1'b0, 8'h02, 64'h0, e, rd, cyc, b);
        checks++; if (rw_at_mv !== 1'b1) begin errors++; $display("FAIL lbu_rw: got %b required 1", rw_at_mv); end
        checks++; if (e !== 2'b00 || rd !== 64'h9a) begin errors++; $display("FAIL lbu_rdata: err=%b rdata=%h required 00/9a", e, rd); end
        access(1'b0, 2'b00, 1'b1, 8'h02, 64'h0, e, rd, cyc, b);
        checks++; if (rd !== 64'hffff_ffff_ffff_ff9a) begin errors++; $display("FAIL lb_signed: got %h required ffffffffffffff9a", rd); end
    endtask

    task automatic test_half_word();
        logic [1:0] e; logic [63:0] rd; int cyc; logic b;
        access(1'b1, 2'b01, 1'b0, 8'h04, 64'hffff_ffff_ffff_bebe, e, rd, cyc, b);
        checks++; if (din_at_mv !== 64'hbebe || type_at_mv !== 2'b01) begin errors++; $display("FAIL sh_din: got %h type %b required bebe/01", din_at_mv, type_at_mv); end
        access(1'b0, 2'b01, 1'b1, 8'h04, 64'h0, e, rd, cyc, b);
        checks++; if (e !== 2'b00 || rd !== 64'hffff_ffff_ffff_bebe) begin errors++; $display("FAIL lh_signed: err=%b rdata=%h required 00/ffffffffffffbebe", e, rd); end
        access(1'b1, 2'b10, 1'b0, 8'h08, 64'h5555_5555_bebe_bebf, e, rd, cyc, b);
        access(1'b0, 2'b10, 1'b0, 8'h08, 64'h0, e, rd, cyc, b);
        checks++; if (e !== 2'b00 || rd !== 64'h0000_0000_bebe_bebf) begin errors++; $display("FAIL lwu: err=%b rdata=%h required 00/00000000bebebebf", e, rd); end
        access(1'b0, 2'b10, 1'b1, 8'h08, 64'h0, e, rd, cyc, b);
        checks++; if (rd !== 64'hffff_ffff_bebe_bebf) begin errors++; $display("FAIL lw_signed: got %h required ffffffffbebebebf", rd); end
    endtask

    task automatic test_dword();
        logic [1:0] e; logic [63:0] rd; int cyc; logic b; int mv0, sv0;
        access(1'b1, 2'b11, 1'b0, 8'h10, 64'hcafe_feaf_bebe_abee, e, rd, cyc, b);
        sv0 = setup_viol;
        mv0 = mv_cycles;
        access(1'b0, 2'b11, 1'b1, 8'h10, 64'h0, e, rd, cyc, b);
        checks++; if (e !== 2'b00 || rd !== 64'hcafe_feaf_bebe_abee) begin errors++; $display("FAIL ld: err=%b rdata=%h required 00/cafefeafbebeabee", e, rd); end
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL ld_busy: got %b required 1", b); end
        checks++; if (cyc !== 11) begin errors++; $display("FAIL ld_latency: got %0d required 11", cyc); end
        checks++; if (mv_cycles - mv0 !== 6) begin errors++; $display("FAIL ld_mv_len: got %0d required 6", mv_cycles - mv0); end
        checks++; if (setup_viol !== 0 || sv0 !== 0) begin errors++; $display("FAIL setup_before_mv: got %0d violations required 0", setup_viol); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL after_done: busy=%b done=%b required 0/0", busy, done); end
    endtask

    task automatic test_misaligned();
        logic [1:0] e; logic [63:0] rd; int cyc; logic b; int mv0; logic [63:0] r0;
        r0  = rdata;
        mv0 = mv_cycles;
        access(1'b0, 2'b10, 1'b0, 8'h06, 64'h0, e, rd, cyc, b);
        checks++; if (e !== 2'b01) begin errors++; $display("FAIL mis_err: got %b required 01", e); end
        checks++; if (cyc !== 0 || b !== 1'b1) begin errors++; $display("FAIL mis_latency: cyc=%0d busy=%b required 0/1", cyc, b); end
        checks++; if (rd !== r0) begin errors++; $display("FAIL mis_rdata_hold: got %h required %h", rd, r0); end
        @(negedge clk);
        checks++; if (mv_cycles !== mv0) begin errors++; $display("FAIL mis_no_mv: got %0d mv cycles required 0", mv_cycles - mv0); end
        access(1'b1, 2'b01, 1'b0, 8'h03, 64'h0, e, rd, cyc, b);
        checks++; if (e !== 2'b01) begin errors++; $display("FAIL mis_half_err: got %b required 01", e); end
        access(1'b1, 2'b11, 1'b0, 8'h0c, 64'h0, e, rd, cyc, b);
        checks++; if (e !== 2'b01) begin errors++; $display("FAIL mis_dword_err: got %b required 01", e); end
    endtask

    task automatic test_timeout();
        logic [1:0] e; logic [63:0] rd; int cyc; logic b; logic [63:0] r0;
        r0 = rdata;
        ram_dead = 1'b1;
        access(1'b0, 2'b00, 1'b0, 8'h02, 64'h0, e, rd, cyc, b);
        checks++; if (e !== 2'b10) begin errors++; $display("FAIL to_err: got %b required 10", e); end
        checks++; if (last_mv_run !== 64) begin errors++; $display("FAIL to_mv_len: got %0d required 64", last_mv_run); end
        checks++; if (cyc !== 66) begin errors++; $display("FAIL to_latency: got %0d required 66", cyc); end
        checks++; if (rd !== r0) begin errors++; $display("FAIL to_rdata_hold: got %h required %h", rd, r0); end
        ram_dead = 1'b0;
        access(1'b0, 2'b00, 1'b0, 8'h02, 64'h0, e, rd, cyc, b);
        checks++; if (e !== 2'b00 || rd !== 64'h9a) begin errors++; $display("FAIL to_recover: err=%b rdata=%h required 00/9a", e, rd); end
    endtask

    task automatic test_reset_in_wait();
        logic [1:0] e; logic [63:0] rd; int cyc; logic b; int n; int d0;
        @(negedge clk);
        req = 1'b1; is_store = 1'b0; size = 2'b11; sign_ext = 1'b0; addr = 8'h10;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!ram_mv && n < 20) begin @(negedge clk); n++; end
        checks++; if (ram_mv !== 1'b1) begin errors++; $display("FAIL rw_reach_wait: mv=%b required 1", ram_mv); end
        @(negedge clk);
        d0 = done_count;
        #2 reset = 1'b1;
        #1;
        checks++; if (ram_mv !== 1'b0 || busy !== 1'b0 || ram_enable !== 1'b0) begin
            errors++; $display("FAIL rw_async_clear: mv=%b busy=%b en=%b required 000", ram_mv, busy, ram_enable);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (done_count !== d0) begin errors++; $display("FAIL rw_no_done: got %0d pulses required 0", done_count - d0); end
        access(1'b0, 2'b11, 1'b0, 8'h10, 64'h0, e, rd, cyc, b);
        checks++; if (e !== 2'b00 || rd !== 64'hcafe_feaf_bebe_abee) begin errors++; $display("FAIL rw_fresh_load: err=%b rdata=%h required 00/cafefeafbebeabee", e, rd); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_byte();
        test_half_word();
        test_dword();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sits directly upstream of ram256x8 and drives its DataIn/address/rw/mv/enable/typeData ports.
- Accepts one load/store request at a time from the CPU datapath and runs the mv/moc handshake against the RAM.
- Returns load data sign- or zero-extended to 64 bits.
- Flags misaligned accesses and handshake timeouts without hanging the pipeline.

Parameters:
- ADDR_W, 8, RAM byte-address width.
- DATA_W, 64, RAM data width (double word).
- TIMEOUT, 64, max cycles mv may stay high waiting for moc before error.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe, sampled only when busy=0.
- is_store  in  1  1=store (RAM rw=WRITE=0), 0=load (rw=READ=1).
- size  in  2  00 byte, 01 halfword, 10 word, 11 doubleword (same encoding as RAM typeData).
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data, low bytes used per size.
- busy  out  1  request in flight.
- done  out  1  one-cycle pulse: access finished (ok or error).
- err  out  2  valid with done: 00 ok, 01 misaligned, 10 timeout.
- rdata  out  DATA_W  extended load result, held until next done.
- ram_data_in  out  DATA_W  to RAM DataIn.
- ram_rw  out  1  to RAM rw.
- ram_address  out  ADDR_W  to RAM address.
- ram_type  out  2  to RAM typeData.
- ram_enable  out  1  to RAM enable.
- ram_mv  out  1  memory operation valid.
- ram_moc  in  1  memory operation complete from RAM, asynchronous; two-flop synchronized internally.
- ram_data_out  in  DATA_W  from RAM DataOut.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, err=00, rdata=0, ram_mv=0, ram_enable=0, ram_rw=1 (READ), ram_address=0, ram_type=00, ram_data_in=0, timeout counter=0, synchronizer flops=0. A reset mid-access abandons the access and produces no done.
- State IDLE: when req=1 and busy=0, register is_store/size/sign_ext/addr/wdata.
  - Alignment check on the registered request: halfword needs addr[0]=0, word needs addr[1:0]=0, dword needs addr[2:0]=0.
  - Misaligned -> DONE with err=01; no RAM port changes, ram_mv never asserted.
  - Aligned -> SETUP.
  - busy=1 from the cycle after req is sampled until the done cycle inclusive.
- State SETUP (1 cycle): drive ram_address, ram_rw, ram_type, ram_data_in=wdata (masked to size, upper bits 0), ram_enable=1; ram_mv=0. Next -> WAIT.
- State WAIT: ram_mv=1; counter increments each cycle.
  - Synchronized moc=1 -> capture ram_data_out for loads; drop ram_mv; -> RELEASE.
  - Counter reaches TIMEOUT -> drop ram_mv; -> RELEASE with err=10 pending.
- State RELEASE: ram_mv=0; wait for synchronized moc=0, then -> DONE. ram_enable drops to 0 on exit.
- State DONE (1 cycle): done=1, err valid; rdata updated for successful loads only (stores and errors leave rdata unchanged). Next -> IDLE, busy=0.
- Load extension:
  - byte: bit 7 is the sign.
  - halfword: bit 15 is the sign.
  - word: bit 31 is the sign.
  - dword: passed through unchanged.
- Minimum aligned latency: req sampled at cycle 0 -> SETUP c1 -> WAIT c2 -> moc seen 2 cycles after RAM asserts it -> RELEASE -> DONE.
- req asserted while busy=1 is ignored (not queued). RAM address arithmetic never wraps, because aligned accesses fit within 256 bytes.
- moc already high on entry to WAIT (stale) is not expected; RELEASE guarantees moc=0 before the next access.

Test Plan:
- Store byte 8'h9a to addr 0x02, then load unsigned -> ram_type=00, ram_rw=0 then 1, done with err=00, rdata=64'h9a; signed load -> rdata=64'hffffffffffffff9a.
- Store halfword 16'hbebe at 0x04, load signed -> rdata=64'hffffffffffffbebe. Store word 32'hbebebebf at 0x08, load zero-extended -> rdata=64'h00000000bebebebf.
- Store dword 64'hcafefeafbebeabee at 0x10, load -> rdata identical; ram_mv high only in WAIT, and ram_address/ram_rw stable one cycle before mv.
- Word access at 0x06 -> done 1 cycle after SETUP would have started, err=01, ram_mv never 1, rdata unchanged.
- RAM model never raises moc -> ram_mv drops after 64 cycles, done with err=10; the next request completes normally.
- Reset asserted during WAIT -> ram_mv=0 and busy=0 immediately with no done pulse; a fresh load afterwards succeeds.
